clock_panel: RTL and testbench

CLOCK_PANEL -- requirements
Module: clock_panel

---
 rtl/clock_panel.sv | 196 +++++++++++++++++++
 tb/tb_clock_panel.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_panel.sv
// clock_panel: front-panel controls for a clock generator.
// Four raw pushbuttons are synchronized and debounced.
// Manual drives the manual clock level.
// Mode cycles a 2-bit clock-mode select and emits a capture strobe.
// Up/down adjust an 8-bit divider limit, with hold-to-auto-repeat.
module clock_panel #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
   parameter logic [23:0] REPEAT_CYCLES   = 24'd1000000,
   parameter logic [7:0]  LIMIT_INIT      = 8'd10
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic       iManualButton,
   input  logic       iModeButton,
   input  logic       iUpButton,
   input  logic       iDownButton,
   output logic       oManualClock,
   output logic [1:0] oState,
   output logic       oStateStrobe,
   output logic [7:0] oLimit
);

   // Button index map used by all per-button vectors
   localparam int B_MAN  = 0;
   localparam int B_MODE = 1;
   localparam int B_UP   = 2;
   localparam int B_DN   = 3;

   // Limit auto-repeat FSM encoding
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_deb;
   logic [3:0]       r_deb_d;
   logic [3:0]       r_press;
   logic [3:0][15:0] r_dcnt;

   logic             r_manual;
   logic [1:0]       r_state;
   logic             r_strobe;

   logic [1:0]       r_fsm;
   logic             r_dir_up;
   logic [23:0]      r_hcnt;
   logic             r_rep_up;
   logic             r_rep_dn;
   logic [7:0]       r_limit;

   logic             w_up;
   logic             w_dn;
   logic             w_one;
   logic             w_qual;
   logic             w_inc;
   logic             w_dec;

   // Two-flop synchronizer for the asynchronous buttons
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {iDownButton, iUpButton, iModeButton, iManualButton};
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
   // the counter restarts at zero after it fires, so it can never wrap
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_deb  <= '0;
         r_dcnt <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_dcnt[i] <= '0;
            end else if (r_dcnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
               r_deb[i]  <= r_sync2[i];
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + 16'd1;
            end
         end
      end
   end

   // Registered rising-edge detect of the debounced levels gives the press pulses
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_deb_d <= '0;
         r_press <= '0;
      end else begin
         r_deb_d <= r_deb;
         r_press <= r_deb & ~r_deb_d;
      end
   end

   // Manual clock is simply the debounced level, registered once more
   always_ff @(posedge iClock) begin
      if (iReset) r_manual <= 1'b0;
      else        r_manual <= r_deb[B_MAN];
   end

   // Mode select advances on each mode press; strobe marks the cycle of the new value
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_state  <= 2'b00;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= r_press[B_MODE];
         if (r_press[B_MODE]) r_state <= r_state + 2'd1;
      end
   end

   assign w_up   = r_deb[B_UP];
   assign w_dn   = r_deb[B_DN];
   assign w_one  = w_up ^ w_dn;
   // Still holding the same single button that started the hold
   assign w_qual = r_dir_up ? (w_up & ~w_dn) : (w_dn & ~w_up);

   // Hold/auto-repeat FSM: one step after HOLD_CYCLES, then one per REPEAT_CYCLES
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_fsm    <= S_IDLE;
         r_dir_up <= 1'b0;
         r_hcnt   <= '0;
         r_rep_up <= 1'b0;
         r_rep_dn <= 1'b0;
      end else begin
         r_rep_up <= 1'b0;
         r_rep_dn <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               r_hcnt <= '0;
               if (w_one) begin
                  r_fsm    <= S_HOLD;
                  r_dir_up <= w_up;
               end
            end
            S_HOLD: begin
               if (!w_qual) begin
                  r_fsm  <= S_IDLE;
                  r_hcnt <= '0;
               end else if (r_hcnt == HOLD_CYCLES - 24'd1) begin
                  r_fsm    <= S_REPEAT;
                  r_hcnt   <= '0;
                  r_rep_up <= r_dir_up;
                  r_rep_dn <= ~r_dir_up;
               end else begin
                  r_hcnt <= r_hcnt + 24'd1;
               end
            end
            S_REPEAT: begin
               if (!w_qual) begin
                  r_fsm  <= S_IDLE;
                  r_hcnt <= '0;
               end else if (r_hcnt == REPEAT_CYCLES - 24'd1) begin
                  r_hcnt   <= '0;
                  r_rep_up <= r_dir_up;
                  r_rep_dn <= ~r_dir_up;
               end else begin
                  r_hcnt <= r_hcnt + 24'd1;
               end
            end
            default: begin
               r_fsm  <= S_IDLE;
               r_hcnt <= '0;
            end
         endcase
      end
   end

   assign w_inc = r_press[B_UP] | r_rep_up;
   assign w_dec = r_press[B_DN] | r_rep_dn;

   // Limit update, saturating in 1..255; simultaneous up and down cancel
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_limit <= LIMIT_INIT;
      end else if (w_inc && !w_dec && r_limit != 8'd255) begin
         r_limit <= r_limit + 8'd1;
      end else if (w_dec && !w_inc && r_limit > 8'd1) begin
         r_limit <= r_limit - 8'd1;
      end
   end

   assign oManualClock = r_manual;
   assign oState       = r_state;
   assign oStateStrobe = r_strobe;
   assign oLimit       = r_limit;

endmodule

// File: tb/tb_clock_panel.sv
// Directed bench for clock_panel with short debounce/hold/repeat timings.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_clock_panel;

   logic       iClock = 1'b0;
   logic       iReset;
   logic       iManualButton;
   logic       iModeButton;
   logic       iUpButton;
   logic       iDownButton;
   logic       oManualClock;
   logic [1:0] oState;
   logic       oStateStrobe;
   logic [7:0] oLimit;

   int vectors     = 0;
   int miscompares = 0;
   int strobes     = 0;
   int bad_strobes = 0;
   logic [1:0] prev_state = 2'b00;

   clock_panel #(
      .DEBOUNCE_CYCLES (16'd4),
      .HOLD_CYCLES     (24'd20),
      .REPEAT_CYCLES   (24'd5),
      .LIMIT_INIT      (8'd10)
   ) dut (
      .iClock        (iClock),
      .iReset        (iReset),
      .iManualButton (iManualButton),
      .iModeButton   (iModeButton),
      .iUpButton     (iUpButton),
      .iDownButton   (iDownButton),
      .oManualClock  (oManualClock),
      .oState        (oState),
      .oStateStrobe  (oStateStrobe),
      .oLimit        (oLimit)
   );

   always #5 iClock = ~iClock;

   // Advance one clock; tally strobes and any strobe without a state change
   task automatic tick();
      @(negedge iClock);
      if (oStateStrobe) begin
         strobes++;
         if (oState == prev_state) bad_strobes++;
      end
      prev_state = oState;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Press mode for n raw cycles, then release and let it settle
   task automatic mode_press(input int n);
      iModeButton = 1'b1;
      ticks(n);
      iModeButton = 1'b0;
      ticks(20);
   endtask

   // Manual pattern: 5 low, 5 high, repeating; quiet before time 0
   function automatic logic man_pat(input int k);
      if (k < 0) return 1'b0;
      return ((k / 5) % 2) == 1;
   endfunction

   initial begin
      int s0;
      iReset = 1'b1;
      iManualButton = 1'b0;
      iModeButton   = 1'b0;
      iUpButton     = 1'b0;
      iDownButton   = 1'b0;
      ticks(2);
      check("rst_state",  oState, 0);
      check("rst_limit",  oLimit, 10);
      check("rst_strobe", oStateStrobe, 0);
      check("rst_manual", oManualClock, 0);
      iReset = 1'b0;
      ticks(3);

      // First mode press: raw high 10 cycles. Sync 2 + debounce 4 + press reg 1,
      // so the state changes on the 8th edge with the strobe in that cycle only.
      s0 = strobes;
      iModeButton = 1'b1;
      ticks(7);
      check("mode_before", oState, 0);
      tick();
      check("mode_after",  oState, 1);
      check("mode_strobe", oStateStrobe, 1);
      tick();
      check("mode_strobe_off", oStateStrobe, 0);
      tick();
      iModeButton = 1'b0;
      ticks(20);
      check("mode_one_strobe", strobes - s0, 1);

      // Three more presses wrap the mode back to 00
      mode_press(10);
      check("mode_10", oState, 2);
      mode_press(10);
      check("mode_11", oState, 3);
      mode_press(10);
      check("mode_wrap", oState, 0);
      check("mode_four_strobes", strobes - s0, 4);

      // A 3-cycle glitch is shorter than the debounce window
      s0 = strobes;
      mode_press(3);
      check("glitch_state",  oState, 0);
      check("glitch_strobe", strobes - s0, 0);

      // Manual clock follows the raw button 7 cycles later
      for (int k = 0; k < 50; k++) begin
         iManualButton = man_pat(k);
         tick();
         check("manual", oManualClock, man_pat(k - 6));
      end
      iManualButton = 1'b0;
      ticks(20);

      // Up held 35 raw cycles from 10: press lands on edge 8, repeats are issued
      // on edges 27/32/37 and land one edge later; release reaches the FSM at 42.
      iUpButton = 1'b1;
      ticks(7);
      check("up_before", oLimit, 10);
      tick();
      check("up_press", oLimit, 11);
      ticks(20);
      check("up_rep1", oLimit, 12);
      ticks(7);
      iUpButton = 1'b0;
      ticks(20);
      check("up_hold", oLimit, 14);

      // Long hold saturates at 255
      iUpButton = 1'b1;
      ticks(1300);
      iUpButton = 1'b0;
      ticks(20);
      check("up_sat", oLimit, 255);

      // Long down hold saturates at 1
      iDownButton = 1'b1;
      ticks(1300);
      iDownButton = 1'b0;
      ticks(20);
      check("dn_sat", oLimit, 1);

      // Down press at 1 stays at 1
      iDownButton = 1'b1;
      ticks(10);
      iDownButton = 1'b0;
      ticks(20);
      check("dn_at_1", oLimit, 1);

      iUpButton = 1'b1;
      ticks(10);
      iUpButton = 1'b0;
      ticks(20);
      check("up_from_1", oLimit, 2);

      // Up and down together: no press step, no auto-repeat
      iUpButton = 1'b1;
      iDownButton = 1'b1;
      ticks(40);
      check("both_held", oLimit, 2);
      iUpButton = 1'b0;
      iDownButton = 1'b0;
      ticks(20);
      check("both_released", oLimit, 2);

      // Reset while repeating in mode 10
      mode_press(10);
      mode_press(10);
      check("pre_rst_state", oState, 2);
      iUpButton = 1'b1;
      ticks(35);
      check("pre_rst_limit", oLimit, 5);
      iReset = 1'b1;
      tick();
      check("mid_rst_state",  oState, 0);
      check("mid_rst_limit",  oLimit, 10);
      check("mid_rst_strobe", oStateStrobe, 0);
      iReset = 1'b0;
      ticks(7);
      check("post_rst_wait", oLimit, 10);
      tick();
      check("post_rst_press", oLimit, 11);
      iUpButton = 1'b0;
      ticks(20);
      check("post_rst_final", oLimit, 11);
      check("post_rst_state", oState, 0);

      check("strobe_without_change", bad_strobes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
